instr_encoder: RTL and testbench

Program-loader block for the single-cycle MIPS-lite datapath: the encoding counterpart of the main control decoder. It accepts symbolic instruction requests (operation class plus register and immediate fields) over a valid/ready handshake and packs each into a 32-bit instruction word. It then writes the words sequentially into instruction memory before the core is released. Memory backpressure is absorbed by a one-entry output register; illegal operations are dropped and flagged.

---
 rtl/mips_lite_pkg.sv | 47 ++++
 rtl/instr_pack.sv | 55 +++++
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite encoding table: op enum, format select, opcode and funct constants.
// Used by both the control decoder and the program loader.
package mips_lite_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_OR     = 4'd3,
      OP_SLT    = 4'd4,
      OP_LW     = 4'd5,
      OP_SW     = 4'd6,
      OP_BEQ    = 4'd7,
      OP_NORI   = 4'd8,
      OP_BLEZAL = 4'd9,
      OP_JALPC  = 4'd10,
      OP_BALN   = 4'd11,
      OP_JMXOR  = 4'd12,
      OP_BRV    = 4'd13,
      OP_RSV14  = 4'd14,
      OP_RSV15  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      FMT_R = 2'd0,
      FMT_I = 2'd1,
      FMT_J = 2'd2
   } fmt_e;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] OPC_LW      = 6'h23;
   localparam logic [5:0] OPC_SW      = 6'h2B;
   localparam logic [5:0] OPC_BEQ     = 6'h04;
   localparam logic [5:0] OPC_NORI    = 6'h0F;
   localparam logic [5:0] OPC_BLEZAL  = 6'h24;
   localparam logic [5:0] OPC_JALPC   = 6'h1F;
   localparam logic [5:0] OPC_BALN    = 6'h1B;

   localparam logic [5:0] FN_ADD      = 6'h20;
   localparam logic [5:0] FN_SUB      = 6'h22;
   localparam logic [5:0] FN_AND      = 6'h24;
   localparam logic [5:0] FN_OR       = 6'h25;
   localparam logic [5:0] FN_SLT      = 6'h2A;
   localparam logic [5:0] FN_JMXOR    = 6'h21;
   localparam logic [5:0] FN_BRV      = 6'h14;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: (op, rs, rt, rd, imm) -> 32-bit instruction word plus legality.
// Custom ops 8-13 are legal only when INSTR_ENCODER_CUSTOM_EN is defined.
module instr_pack
   import mips_lite_pkg::*;
(
   input  op_e         op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [25:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   fmt_e       fmt;
   logic [5:0] opcode;
   logic [5:0] funct;

   always_comb begin
      fmt    = FMT_R;
      opcode = OPC_SPECIAL;
      funct  = '0;
      legal  = 1'b1;
      case (op)
         OP_ADD:    funct = FN_ADD;
         OP_SUB:    funct = FN_SUB;
         OP_AND:    funct = FN_AND;
         OP_OR:     funct = FN_OR;
         OP_SLT:    funct = FN_SLT;
         OP_LW:     begin fmt = FMT_I; opcode = OPC_LW;  end
         OP_SW:     begin fmt = FMT_I; opcode = OPC_SW;  end
         OP_BEQ:    begin fmt = FMT_I; opcode = OPC_BEQ; end
`ifdef INSTR_ENCODER_CUSTOM_EN
         OP_NORI:   begin fmt = FMT_I; opcode = OPC_NORI;   end
         OP_BLEZAL: begin fmt = FMT_I; opcode = OPC_BLEZAL; end
         OP_JALPC:  begin fmt = FMT_I; opcode = OPC_JALPC;  end
         OP_BALN:   begin fmt = FMT_J; opcode = OPC_BALN;   end
         OP_JMXOR:  funct = FN_JMXOR;
         OP_BRV:    funct = FN_BRV;
`endif
         default:   legal = 1'b0;
      endcase
   end

   always_comb begin
      word = '0;
      case (fmt)
         FMT_R:   word = {OPC_SPECIAL, rs, rt, rd, 5'b0, funct};
         FMT_I:   word = {opcode, rs, rt, imm[15:0]};
         FMT_J:   word = {opcode, imm};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic requests and writes them sequentially into instruction memory.
// Optional INSTR_ENCODER_CUSTOM_EN enables the custom ops 8-13 (handled in instr_pack).
module instr_encoder
   import mips_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [3:0]               req_op,
   input  logic [4:0]               req_rs,
   input  logic [4:0]               req_rt,
   input  logic [4:0]               req_rd,
   input  logic [25:0]              req_imm,
   output logic                     imem_we,
   output logic [31:0]              imem_addr,
   output logic [31:0]              imem_wdata,
   input  logic                     imem_busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     err
);

   localparam int unsigned   CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_FULL = 2'd2
   } state_e;

   state_e        state, state_nxt;
   logic [31:0]   word_q;
   logic [31:0]   addr_q;
   logic [CW-1:0] count_q;
   logic          err_q;
   logic [31:0]   pack_word;
   logic          pack_legal;
   logic          out_valid, complete, last_slot, accept;

   instr_pack u_pack (
      .op    (op_e'(req_op)),
      .rs    (req_rs),
      .rt    (req_rt),
      .rd    (req_rd),
      .imm   (req_imm),
      .word  (pack_word),
      .legal (pack_legal)
   );

   assign out_valid = (state == S_PEND);
   assign complete  = out_valid & ~imem_busy;
   // The pending word already claims the final slot, so no further request fits.
   assign last_slot = out_valid & (count_q == LAST);
   assign req_ready = (state != S_FULL) & ~(out_valid & imem_busy) & ~start & ~last_slot;
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept && pack_legal) state_nxt = S_PEND;
            S_PEND: begin
               if (complete) begin
                  if (count_q == LAST)          state_nxt = S_FULL;
                  else if (accept && pack_legal) state_nxt = S_PEND;
                  else                           state_nxt = S_IDLE;
               end
            end
            S_FULL:  state_nxt = S_FULL;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         word_q  <= '0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            if (complete) begin
               addr_q  <= addr_q + 32'd4;
               count_q <= count_q + 1'b1;
            end
            if (accept) begin
               if (pack_legal) word_q <= pack_word;
               else            err_q  <= 1'b1;
            end
         end
      end
   end

   assign imem_we    = out_valid;
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign count      = count_q;
   assign full       = (state == S_FULL);
   assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: two instances (DEPTH 256 and DEPTH 4) against a transaction-level model.
module tb_instr_encoder;

   localparam logic [31:0] SBASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset, start, req_valid, imem_busy;
   logic [3:0]  req_op;
   logic [4:0]  req_rs, req_rt, req_rd;
   logic [25:0] req_imm;
   logic [1:0]  rdy, we, full, err;
   logic [1:0][31:0] addr, wdata;
   logic [8:0]  cnt0;
   logic [2:0]  cnt1;

   always #5 clk = ~clk;

   instr_encoder u_dut (
      .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wdata[0]), .imem_busy(imem_busy),
      .count(cnt0), .full(full[0]), .err(err[0])
   );

   instr_encoder #(.BASE_ADDR(SBASE), .DEPTH(4)) u_small (
      .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wdata[1]), .imem_busy(imem_busy),
      .count(cnt1), .full(full[1]), .err(err[1])
   );

   int unsigned m_depth [2] = '{256, 4};
   logic [31:0] m_base  [2] = '{32'h0, SBASE};
   bit          m_pend  [2];
   logic [31:0] m_word  [2];
   int unsigned m_cnt   [2];
   bit          m_err   [2];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset(input int i);
      m_pend[i] = 1'b0;
      m_word[i] = '0;
      m_cnt[i]  = 0;
      m_err[i]  = 1'b0;
   endfunction

   // Returns {legal, word}; words built from field weights, not bit concatenation.
   function automatic logic [32:0] ref_encode(input logic [3:0] op, input logic [4:0] a, b, c,
                                               input logic [25:0] im);
      int    kind;
      longint code, w;
      kind = -1; code = 0; w = 0;
      case (op)
         0:  begin kind = 0; code = 'h20; end
         1:  begin kind = 0; code = 'h22; end
         2:  begin kind = 0; code = 'h24; end
         3:  begin kind = 0; code = 'h25; end
         4:  begin kind = 0; code = 'h2A; end
         5:  begin kind = 1; code = 'h23; end
         6:  begin kind = 1; code = 'h2B; end
         7:  begin kind = 1; code = 'h04; end
`ifdef INSTR_ENCODER_CUSTOM_EN
         8:  begin kind = 1; code = 'h0F; end
         9:  begin kind = 1; code = 'h24; end
         10: begin kind = 1; code = 'h1F; end
         11: begin kind = 2; code = 'h1B; end
         12: begin kind = 0; code = 'h21; end
         13: begin kind = 0; code = 'h14; end
`endif
         default: kind = -1;
      endcase
      if (kind == 0)      w = longint'(a) * 2097152 + longint'(b) * 65536 + longint'(c) * 2048 + code;
      else if (kind == 1) w = code * 67108864 + longint'(a) * 2097152 + longint'(b) * 65536 + (longint'(im) % 65536);
      else if (kind == 2) w = code * 67108864 + longint'(im);
      return {kind >= 0, w[31:0]};
   endfunction

   task automatic cycle(input bit rst, input bit st, input bit v, input logic [3:0] op,
                        input logic [4:0] a, b, c, input logic [25:0] im, input bit busy);
      logic [32:0] e;
      bit          erdy, efull;
      logic [31:0] gcnt;
      @(negedge clk);
      reset = rst; start = st; req_valid = v; req_op = op;
      req_rs = a; req_rt = b; req_rd = c; req_imm = im; imem_busy = busy;
      #1;
      for (int i = 0; i < 2; i++) begin
         efull = (m_cnt[i] == m_depth[i]);
         erdy  = !efull && !(m_pend[i] && busy) && !st && (m_cnt[i] + 32'(m_pend[i]) != m_depth[i]);
         gcnt  = (i == 0) ? 32'(cnt0) : 32'(cnt1);
         chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(erdy));
         chk($sformatf("we[%0d]", i), 32'(we[i]), 32'(m_pend[i]));
         chk($sformatf("addr[%0d]", i), addr[i], m_base[i] + 32'(4 * m_cnt[i]));
         chk($sformatf("wdata[%0d]", i), wdata[i], m_word[i]);
         chk($sformatf("count[%0d]", i), gcnt, m_cnt[i]);
         chk($sformatf("full[%0d]", i), 32'(full[i]), 32'(efull));
         chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
         if (rst) model_reset(i);
         else if (st) begin
            m_pend[i] = 1'b0; m_cnt[i] = 0; m_err[i] = 1'b0;
         end else begin
            if (m_pend[i] && !busy) begin
               m_cnt[i]++;
               m_pend[i] = 1'b0;
            end
            if (v && erdy) begin
               e = ref_encode(op, a, b, c, im);
               if (e[32]) begin m_pend[i] = 1'b1; m_word[i] = e[31:0]; end
               else m_err[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input bit busy);
      cycle(0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, busy);
   endtask

   task automatic req(input logic [3:0] op, input logic [4:0] a, b, c, input logic [25:0] im);
      cycle(0, 0, 1, op, a, b, c, im, 0);
   endtask

   task automatic do_start();
      cycle(0, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; req_valid = 1'b0; imem_busy = 1'b0;
      req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
      repeat (2) @(posedge clk);
      model_reset(0);
      model_reset(1);

      // ADD after reset
      req(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
      idle(0);
      chk("add_we", 32'(we[0]), 32'd1);
      chk("add_addr", addr[0], 32'h0);
      chk("add_data", wdata[0], 32'h0022_1820);
      idle(0);
      chk("add_count", 32'(cnt0), 32'd1);

      // LW then NORI back-to-back
      do_start();
      req(4'd5, 5'd29, 5'd8, 5'd0, 26'd4);
      req(4'd8, 5'd4, 5'd5, 5'd0, 26'hFFFF);
      chk("lw_data", wdata[0], 32'h8FA8_0004);
      chk("lw_addr", addr[0], 32'h0);
      idle(0);
`ifdef INSTR_ENCODER_CUSTOM_EN
      chk("nori_data", wdata[0], 32'h3C85_FFFF);
      chk("nori_addr", addr[0], 32'h4);
`else
      chk("nori_err", 32'(err[0]), 32'd1);
      chk("nori_nowrite", 32'(we[0]), 32'd0);
`endif
      idle(0);

      // JMXOR and BALN
      req(4'd12, 5'd6, 5'd7, 5'd8, 26'd0);
      idle(0);
`ifdef INSTR_ENCODER_CUSTOM_EN
      chk("jmxor_data", wdata[0], 32'h00C7_4021);
`else
      chk("jmxor_nowrite", 32'(we[0]), 32'd0);
`endif
      req(4'd11, 5'd0, 5'd0, 5'd0, 26'h100);
      idle(0);
`ifdef INSTR_ENCODER_CUSTOM_EN
      chk("baln_data", wdata[0], 32'h6C00_0100);
`else
      chk("baln_err", 32'(err[0]), 32'd1);
`endif
      idle(0);

      // Backpressure: 3 stall cycles hold the pending word
      do_start();
      req(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         chk("stall_ready", 32'(rdy[0]), 32'd0);
         chk("stall_data", wdata[0], 32'h0022_1820);
         chk("stall_addr", addr[0], 32'h0);
      end
      idle(0);
      idle(0);
      chk("stall_count", 32'(cnt0), 32'd1);

      // DEPTH=4 fill, refusal, then start and an illegal op
      do_start();
      for (int k = 0; k < 5; k++) req(4'(k % 5), 5'(k), 5'(k + 1), 5'(k + 2), 26'(k));
      idle(0);
      chk("small_full", 32'(full[1]), 32'd1);
      chk("small_ready", 32'(rdy[1]), 32'd0);
      chk("small_count", 32'(cnt1), 32'd4);
      do_start();
      idle(0);
      chk("restart_addr", addr[1], SBASE);
      chk("restart_count", 32'(cnt1), 32'd0);
      chk("restart_full", 32'(full[1]), 32'd0);
      req(4'd14, 5'd1, 5'd1, 5'd1, 26'd1);
      idle(0);
      chk("op14_err", 32'(err[1]), 32'd1);
      chk("op14_nowrite", 32'(we[1]), 32'd0);

      // Reset mid-write discards the pending word
      req(4'd1, 5'd3, 5'd4, 5'd5, 26'd0);
      cycle(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 0);
      idle(0);
      chk("rst_we", 32'(we[0]), 32'd0);
      chk("rst_count", 32'(cnt0), 32'd0);

      for (int k = 0; k < 2000; k++)
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
               4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
               26'($urandom), $urandom_range(0, 9) < 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
